rv3n_dc_issue_queue: RTL and testbench



---
 rtl/rv3n_dc_issue_queue.sv | 196 +++++++++++++++++++
 tb/tb_rv3n_dc_issue_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv3n_dc_issue_queue.sv
// rv3n_dc_issue_queue
// Decode-side instruction queue feeding the ID stage. Decoded groups of up to
// PNUM instructions are compacted into program order and stored in a circular
// buffer. The oldest PNUM entries are presented on dc2id_*.
// Optional feature macro: RV3N_DC_BYPASS_EN. When it is defined, an empty
// queue forwards the incoming group to ID in the same cycle.

`ifndef PNUM
`define PNUM 3
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DC_LEN
`define DC_LEN 32
`endif

module rv3n_dc_issue_queue #(
  parameter int PNUM   = `PNUM,
  parameter int XLEN   = `XLEN,
  parameter int DC_LEN = `DC_LEN,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stage_dc_clear,
  input  logic [PNUM-1:0]        in_valid,
  input  logic [PNUM*XLEN-1:0]   in_instr,
  input  logic [PNUM-1:0]        in_predict,
  input  logic [PNUM*DC_LEN-1:0] in_arguments,
  input  logic [PNUM*XLEN-1:0]   in_pc,
  output logic                   dc_ready,
  input  logic                   id2dc_ready,
  output logic [PNUM-1:0]        dc2id_valid,
  output logic [PNUM*XLEN-1:0]   dc2id_instr,
  output logic [PNUM-1:0]        dc2id_predict,
  output logic [PNUM*DC_LEN-1:0] dc2id_arguments,
  output logic [PNUM*XLEN-1:0]   dc2id_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PNUM_C  = CNT_W'(PNUM);

  // Number of set bits in a slot-valid vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [PNUM-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < PNUM; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Valid bits strictly below slot idx: the compacted position of that slot.
  function automatic logic [CNT_W-1:0] prefix_count(input logic [PNUM-1:0] v,
                                                    input int idx);
    logic [PNUM-1:0] mask;
    mask = (PNUM'(1) << idx) - PNUM'(1);
    return popcount(v & mask);
  endfunction

  // Storage is data-only and deliberately left unreset.
  logic [XLEN-1:0]   instr_q [DEPTH];
  logic              pred_q  [DEPTH];
  logic [DC_LEN-1:0] args_q  [DEPTH];
  logic [XLEN-1:0]   pc_q    [DEPTH];

  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CNT_W-1:0] slot_pos [PNUM];
  logic [CNT_W-1:0] group_size;
  logic [CNT_W-1:0] n_pres;
  logic [CNT_W-1:0] pushed;
  logic [CNT_W-1:0] popped;
  logic             push_en;
  logic             pop_en;

  // Compacted position of every incoming slot and total size of the group.
  always_comb begin
    for (int i = 0; i < PNUM; i++) begin
      slot_pos[i] = prefix_count(in_valid, i);
    end
    group_size = popcount(in_valid);
  end

  // Room check uses only the registered count; a same-cycle pop is not credited.
  always_comb begin
    dc_ready = (DEPTH_C - count_q) >= PNUM_C;
    n_pres   = (count_q < PNUM_C) ? count_q : PNUM_C;
  end

`ifdef RV3N_DC_BYPASS_EN
  logic                   bypass_act;
  logic [PNUM-1:0]        cmp_valid;
  logic [PNUM*XLEN-1:0]   cmp_instr;
  logic [PNUM-1:0]        cmp_predict;
  logic [PNUM*DC_LEN-1:0] cmp_arguments;
  logic [PNUM*XLEN-1:0]   cmp_pc;

  // Compacted view of the incoming group, used when the queue is empty.
  always_comb begin
    bypass_act    = (count_q == '0) && !stage_dc_clear;
    cmp_valid     = '0;
    cmp_instr     = '0;
    cmp_predict   = '0;
    cmp_arguments = '0;
    cmp_pc        = '0;
    for (int k = 0; k < PNUM; k++) begin
      cmp_valid[k] = CNT_W'(k) < group_size;
      for (int i = 0; i < PNUM; i++) begin
        if (in_valid[i] && (slot_pos[i] == CNT_W'(k))) begin
          cmp_instr[k*XLEN +: XLEN]       = in_instr[i*XLEN +: XLEN];
          cmp_predict[k]                  = in_predict[i];
          cmp_arguments[k*DC_LEN +: DC_LEN] = in_arguments[i*DC_LEN +: DC_LEN];
          cmp_pc[k*XLEN +: XLEN]          = in_pc[i*XLEN +: XLEN];
        end
      end
    end
  end
`endif

  // Handshake decisions: a clear suppresses both push and pop.
  always_comb begin
    pop_en  = id2dc_ready && !stage_dc_clear;
`ifdef RV3N_DC_BYPASS_EN
    push_en = dc_ready && !stage_dc_clear && (in_valid != '0)
              && !(bypass_act && id2dc_ready);
`else
    push_en = dc_ready && !stage_dc_clear && (in_valid != '0);
`endif
    pushed  = push_en ? group_size : '0;
    popped  = pop_en ? n_pres : '0;
    rptr_d  = rptr_q + PTR_W'(popped);
    wptr_d  = wptr_q + PTR_W'(pushed);
    count_d = count_q + pushed - popped;
  end

  // Present the oldest entries; unused slots drive all-zero fields.
  always_comb begin
    dc2id_valid     = '0;
    dc2id_instr     = '0;
    dc2id_predict   = '0;
    dc2id_arguments = '0;
    dc2id_pc        = '0;
    for (int k = 0; k < PNUM; k++) begin
      if (CNT_W'(k) < n_pres) begin
        dc2id_valid[k]                      = 1'b1;
        dc2id_instr[k*XLEN +: XLEN]         = instr_q[rptr_q + PTR_W'(k)];
        dc2id_predict[k]                    = pred_q[rptr_q + PTR_W'(k)];
        dc2id_arguments[k*DC_LEN +: DC_LEN] = args_q[rptr_q + PTR_W'(k)];
        dc2id_pc[k*XLEN +: XLEN]            = pc_q[rptr_q + PTR_W'(k)];
      end
    end
`ifdef RV3N_DC_BYPASS_EN
    if (bypass_act) begin
      dc2id_valid     = cmp_valid;
      dc2id_instr     = cmp_instr;
      dc2id_predict   = cmp_predict;
      dc2id_arguments = cmp_arguments;
      dc2id_pc        = cmp_pc;
    end
`endif
  end

  // Write each valid incoming slot at its compacted offset from wptr.
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < PNUM; i++) begin
        if (in_valid[i]) begin
          instr_q[wptr_q + PTR_W'(slot_pos[i])] <= in_instr[i*XLEN +: XLEN];
          pred_q[wptr_q + PTR_W'(slot_pos[i])]  <= in_predict[i];
          args_q[wptr_q + PTR_W'(slot_pos[i])]  <= in_arguments[i*DC_LEN +: DC_LEN];
          pc_q[wptr_q + PTR_W'(slot_pos[i])]    <= in_pc[i*XLEN +: XLEN];
        end
      end
    end
  end

  // Pointer and occupancy state; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || stage_dc_clear) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rv3n_dc_issue_queue.sv
// Self-checking bench for rv3n_dc_issue_queue (PNUM=3, DEPTH=8).
module tb_rv3n_dc_issue_queue;

  localparam int P  = 3;
  localparam int D  = 8;
  localparam int XL = 32;
  localparam int DL = 16;
`ifdef RV3N_DC_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, clr, idr;
  logic [P-1:0]    v;
  logic [P*XL-1:0] instr, pc;
  logic [P-1:0]    pred;
  logic [P*DL-1:0] args;
  logic            dc_ready;
  logic [P-1:0]    o_valid, o_pred;
  logic [P*XL-1:0] o_instr, o_pc;
  logic [P*DL-1:0] o_args;

  rv3n_dc_issue_queue #(.PNUM(P), .XLEN(XL), .DC_LEN(DL), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .stage_dc_clear(clr),
    .in_valid(v), .in_instr(instr), .in_predict(pred),
    .in_arguments(args), .in_pc(pc),
    .dc_ready(dc_ready), .id2dc_ready(idr),
    .dc2id_valid(o_valid), .dc2id_instr(o_instr), .dc2id_predict(o_pred),
    .dc2id_arguments(o_args), .dc2id_pc(o_pc)
  );

  typedef struct packed {
    logic [XL-1:0] instr;
    logic          pred;
    logic [DL-1:0] args;
    logic [XL-1:0] pc;
  } ent_t;

  // Reference: the queue contents in program order, oldest at index 0.
  ent_t mq[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic c, input logic [P-1:0] vv,
                        input logic ir, input logic [31:0] base);
    rst = r; clr = c; v = vv; idr = ir;
    for (int i = 0; i < P; i++) begin
      pc[i*XL +: XL]    = base + 32'(4 * i);
      instr[i*XL +: XL] = (base + 32'(4 * i)) ^ 32'hA5A5_0000;
      args[i*DL +: DL]  = 16'((base + 32'(4 * i)) ^ 32'h3C3C);
      pred[i]           = pc[i*XL + 2];
    end
  endtask

  // Expected bundle from the queue contents (or the raw group when bypassing).
  task automatic model_check();
    logic [P-1:0] ev, epr;
    logic [P*XL-1:0] ei, ep;
    logic [P*DL-1:0] ea;
    logic er;
    int n, k;
    ev = '0; epr = '0; ei = '0; ep = '0; ea = '0;
    n  = (mq.size() < P) ? mq.size() : P;
    er = (D - mq.size()) >= P;
    if (BYP && mq.size() == 0 && !clr) begin
      k = 0;
      for (int i = 0; i < P; i++) begin
        if (v[i]) begin
          ev[k] = 1'b1;
          ei[k*XL +: XL] = instr[i*XL +: XL];
          epr[k] = pred[i];
          ea[k*DL +: DL] = args[i*DL +: DL];
          ep[k*XL +: XL] = pc[i*XL +: XL];
          k++;
        end
      end
    end else begin
      for (int j = 0; j < n; j++) begin
        ev[j] = 1'b1;
        ei[j*XL +: XL] = mq[j].instr;
        epr[j] = mq[j].pred;
        ea[j*DL +: DL] = mq[j].args;
        ep[j*XL +: XL] = mq[j].pc;
      end
    end
    chk("model_ready", dc_ready, er);
    chk("model_valid", o_valid, ev);
    chk("model_pc", o_pc, ep);
    chk("model_instr", o_instr, ei);
    chk("model_predict", o_pred, epr);
    chk("model_args", o_args, ea);
  endtask

  task automatic model_update();
    int n;
    bit empty, rdy;
    if (rst || clr) begin
      mq.delete();
      return;
    end
    empty = (mq.size() == 0);
    rdy   = (D - mq.size()) >= P;
    n     = (mq.size() < P) ? mq.size() : P;
    if (idr) repeat (n) void'(mq.pop_front());
    if (rdy && v != '0 && !(BYP && empty && idr)) begin
      for (int i = 0; i < P; i++) begin
        if (v[i]) mq.push_back('{instr[i*XL +: XL], pred[i], args[i*DL +: DL], pc[i*XL +: XL]});
      end
    end
  endtask

  // Called at the falling edge: check against the model, then take the edge.
  task automatic finish_cycle();
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic          c;
    logic [P-1:0]  vv;
    logic          ir;
    logic [31:0]   base;
    logic [P-1:0]  ev;
    logic          er;
    logic [P*XL-1:0] epc;
  } vec_t;

  vec_t tbl[17];
  logic [31:0] seq_pc;

  initial begin
    tbl[0]  = '{1'b0, 3'b111, 1'b0, 32'h100, 3'b000, 1'b1, 96'h0};
    tbl[1]  = '{1'b0, 3'b000, 1'b0, 32'h0,   3'b111, 1'b1, {32'h108, 32'h104, 32'h100}};
    tbl[2]  = '{1'b0, 3'b000, 1'b0, 32'h0,   3'b111, 1'b1, {32'h108, 32'h104, 32'h100}};
    tbl[3]  = '{1'b0, 3'b000, 1'b0, 32'h0,   3'b111, 1'b1, {32'h108, 32'h104, 32'h100}};
    tbl[4]  = '{1'b0, 3'b000, 1'b1, 32'h0,   3'b111, 1'b1, {32'h108, 32'h104, 32'h100}};
    tbl[5]  = '{1'b0, 3'b000, 1'b0, 32'h0,   3'b000, 1'b1, 96'h0};
    tbl[6]  = '{1'b0, 3'b101, 1'b0, 32'h200, 3'b000, 1'b1, 96'h0};
    tbl[7]  = '{1'b0, 3'b000, 1'b0, 32'h0,   3'b011, 1'b1, {32'h0, 32'h208, 32'h200}};
    tbl[8]  = '{1'b0, 3'b000, 1'b1, 32'h0,   3'b011, 1'b1, {32'h0, 32'h208, 32'h200}};
    tbl[9]  = '{1'b0, 3'b111, 1'b0, 32'h300, 3'b000, 1'b1, 96'h0};
    tbl[10] = '{1'b0, 3'b111, 1'b0, 32'h310, 3'b111, 1'b1, {32'h308, 32'h304, 32'h300}};
    tbl[11] = '{1'b0, 3'b111, 1'b0, 32'h320, 3'b111, 1'b0, {32'h308, 32'h304, 32'h300}};
    tbl[12] = '{1'b0, 3'b000, 1'b1, 32'h0,   3'b111, 1'b0, {32'h308, 32'h304, 32'h300}};
    tbl[13] = '{1'b0, 3'b000, 1'b0, 32'h0,   3'b111, 1'b1, {32'h318, 32'h314, 32'h310}};
    tbl[14] = '{1'b0, 3'b011, 1'b0, 32'h330, 3'b111, 1'b1, {32'h318, 32'h314, 32'h310}};
    tbl[15] = '{1'b1, 3'b111, 1'b1, 32'h340, 3'b111, 1'b1, {32'h318, 32'h314, 32'h310}};
    tbl[16] = '{1'b0, 3'b000, 1'b0, 32'h0,   3'b000, 1'b1, 96'h0};

    set_in(1'b1, 1'b0, '0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    set_in(1'b0, 1'b0, '0, 1'b0, 32'h0);
    mq.delete();

    @(negedge clk);
    chk("reset_valid", o_valid, 3'b000);
    chk("reset_ready", dc_ready, 1'b1);
    chk("reset_pc", o_pc, 96'h0);
    finish_cycle();

`ifndef RV3N_DC_BYPASS_EN
    for (int i = 0; i < 17; i++) begin
      set_in(1'b0, tbl[i].c, tbl[i].vv, tbl[i].ir, tbl[i].base);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_ready", i), dc_ready, tbl[i].er);
      chk($sformatf("tbl%0d_pc", i), o_pc, tbl[i].epc);
      finish_cycle();
    end

    // Steady push and pop of full groups, wrapping the 8-entry ring.
    for (int j = 0; j < 10; j++) begin
      set_in(1'b0, 1'b0, 3'b111, 1'b1, 32'h400 + 32'(12 * j));
      @(negedge clk);
      if (j == 0) begin
        chk("wrap_first_valid", o_valid, 3'b000);
      end else begin
        chk($sformatf("wrap%0d_valid", j), o_valid, 3'b111);
        chk($sformatf("wrap%0d_ready", j), dc_ready, 1'b1);
        chk($sformatf("wrap%0d_pc", j), o_pc,
            {32'h408 + 32'(12 * (j - 1)), 32'h404 + 32'(12 * (j - 1)), 32'h400 + 32'(12 * (j - 1))});
      end
      finish_cycle();
    end
    set_in(1'b0, 1'b1, 3'b000, 1'b0, 32'h0);
    @(negedge clk);
    finish_cycle();
`else
    // Empty queue: the group goes straight through and nothing is stored.
    set_in(1'b0, 1'b0, 3'b111, 1'b1, 32'h500);
    @(negedge clk);
    chk("bypass_valid", o_valid, 3'b111);
    chk("bypass_pc", o_pc, {32'h508, 32'h504, 32'h500});
    chk("bypass_ready", dc_ready, 1'b1);
    finish_cycle();
    set_in(1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
    @(negedge clk);
    chk("bypass_after_valid", o_valid, 3'b000);
    finish_cycle();
`endif

    // Random traffic with alternating fill-heavy and drain-heavy phases.
    seq_pc = 32'h1000;
    for (int j = 0; j < 600; j++) begin
      rst = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 39) == 0);
      v   = P'($urandom_range(0, 7));
      if ((j % 64) < 32) idr = ($urandom_range(0, 3) == 0);
      else               idr = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < P; i++) begin
        pc[i*XL +: XL]    = seq_pc;
        seq_pc            = seq_pc + 32'd4;
        instr[i*XL +: XL] = $urandom;
        args[i*DL +: DL]  = 16'($urandom);
        pred[i]           = 1'($urandom);
      end
      @(negedge clk);
      finish_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
